// File: rtl/hydra_pkg.sv
// Shared Hydra types and constants.
// Used by the RX arbiter and its round-robin picker.
package hydra_pkg;

    localparam int HYDRA_NPORTS = 4;
    localparam int HYDRA_PTR_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        FLAG,
        GUARD
    } rx_arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set bit of req
// at or above ptr, wrapping from N-1 back to 0.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        valid  = |req;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                winner = W'((int'(ptr) + k) % N);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hydra_rx_arbiter.sv
// Round-robin arbiter from the four RX UARTs into comms_ctrl,
// with a settle guard after each unload and per-port counters.
module hydra_rx_arbiter
    import hydra_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int NPORTS       = HYDRA_NPORTS,
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                             clk,
    input  logic                             reset_n_clk,
    input  logic [NPORTS-1:0][WIDTH-2:0]     rx_data_uart,
    input  logic [NPORTS-1:0]                rx_empty_uart,
    input  logic [NPORTS-1:0]                enable_posi,
    input  logic                             comms_busy,
    input  logic                             clear_counts,
    output logic [WIDTH-2:0]                 rx_data,
    output logic                             rx_data_flag,
    output logic [NPORTS-1:0]                uld_rx_data_uart,
    output logic [HYDRA_PTR_W-1:0]           grant_port,
    output logic                             arb_busy,
    output logic [NPORTS-1:0][CNT_BITS-1:0]  rx_count
);

    localparam int PW = HYDRA_PTR_W;
    localparam int GW = 3;
    localparam logic [NPORTS-1:0] ONE = NPORTS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    rx_arb_state_t     state_q, state_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win;
    logic              win_vld;
    logic              grant;
    logic              flag_d;
    logic [NPORTS-1:0] req;

    assign req      = enable_posi & ~rx_empty_uart;
    assign arb_busy = (state_q != IDLE);

    rr_priority_pick #(
        .N (NPORTS),
        .W (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        grant   = 1'b0;
        flag_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!comms_busy && win_vld) begin
                    grant   = 1'b1;
                    state_d = FLAG;
                end
            end
            FLAG: begin
                flag_d  = 1'b1;
                guard_d = GW'(GUARD_CYCLES);
                state_d = GUARD;
            end
            GUARD: begin
                guard_d = guard_q - 1'b1;
                if (guard_q <= GW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            state_q          <= IDLE;
            guard_q          <= '0;
            ptr_q            <= '0;
            rx_data          <= '0;
            rx_data_flag     <= 1'b0;
            uld_rx_data_uart <= '0;
            grant_port       <= '0;
        end else begin
            state_q          <= state_d;
            guard_q          <= guard_d;
            rx_data_flag     <= flag_d;
            uld_rx_data_uart <= grant ? (ONE << win) : '0;
            if (grant) begin
                rx_data    <= rx_data_uart[win];
                grant_port <= win;
                ptr_q      <= win + 1'b1;
            end
        end
    end

    // clear has priority over a coincident grant increment
    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            rx_count <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (clear_counts) begin
                    rx_count[i] <= '0;
                end else if (grant && win == PW'(i)
                             && rx_count[i] != CNT_MAX) begin
                    rx_count[i] <= rx_count[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hydra_rx_arbiter.sv
// Bench for hydra_rx_arbiter: vector table, directed corner
// sequences and random traffic against a timeline model.
module tb_hydra_rx_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int G  = 2;
    localparam int CB = 16;

    typedef logic [W-2:0] data_t;

    logic                   clk = 1'b0;
    logic                   reset_n_clk;
    logic [N-1:0][W-2:0]    rx_data_uart;
    logic [N-1:0]           rx_empty_uart;
    logic [N-1:0]           enable_posi;
    logic                   comms_busy;
    logic                   clear_counts;
    data_t                  rx_data;
    logic                   rx_data_flag;
    logic [N-1:0]           uld;
    logic [1:0]             grant_port;
    logic                   arb_busy;
    logic [N-1:0][CB-1:0]   rx_count;
    data_t                  rx_data_b;
    logic                   flag_b;
    logic [N-1:0]           uld_b;
    logic [1:0]             grant_b;
    logic                   busy_b;
    logic [N-1:0][1:0]      rx_count_b;

    hydra_rx_arbiter #(
        .WIDTH(W), .NPORTS(N), .GUARD_CYCLES(G), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset_n_clk(reset_n_clk),
        .rx_data_uart(rx_data_uart), .rx_empty_uart(rx_empty_uart),
        .enable_posi(enable_posi), .comms_busy(comms_busy),
        .clear_counts(clear_counts), .rx_data(rx_data),
        .rx_data_flag(rx_data_flag), .uld_rx_data_uart(uld),
        .grant_port(grant_port), .arb_busy(arb_busy),
        .rx_count(rx_count)
    );

    hydra_rx_arbiter #(
        .WIDTH(W), .NPORTS(N), .GUARD_CYCLES(G), .CNT_BITS(2)
    ) dut_sat (
        .clk(clk), .reset_n_clk(reset_n_clk),
        .rx_data_uart(rx_data_uart), .rx_empty_uart(rx_empty_uart),
        .enable_posi(enable_posi), .comms_busy(comms_busy),
        .clear_counts(clear_counts), .rx_data(rx_data_b),
        .rx_data_flag(flag_b), .uld_rx_data_uart(uld_b),
        .grant_port(grant_b), .arb_busy(busy_b),
        .rx_count(rx_count_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int last_p;
    int m_ptr;
    int pop_port;
    int unsigned m_cnt[N];
    int unsigned m_cnt2[N];
    data_t e_data;
    logic e_flag;
    logic [N-1:0] e_uld;
    logic [1:0] e_grant;
    logic e_busy;
    bit env_mode = 1'b0;
    data_t q[N][$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        last_p  = -100;
        m_ptr   = 0;
        e_data  = '0;
        e_flag  = 1'b0;
        e_uld   = '0;
        e_grant = '0;
        e_busy  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_cnt2[i] = 0;
        end
    endtask

    // Timeline model: a grant at edge p gives uld at p, flag at p+1,
    // busy over p..p+G, and the next grant no earlier than p+G+2.
    task automatic predict();
        logic [N-1:0] req;
        int w;
        bit ok;
        req = enable_posi & ~rx_empty_uart;
        e_flag = (last_p == t - 1);
        ok = (t >= last_p + G + 2) && !comms_busy && (req != '0);
        if (clear_counts)
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_cnt2[i] = 0;
            end
        e_uld = '0;
        pop_port = -1;
        if (ok) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            e_uld[w] = 1'b1;
            e_data   = rx_data_uart[w];
            e_grant  = 2'(w);
            m_ptr    = (w + 1) % N;
            if (!clear_counts) begin
                if (m_cnt[w] < 65535) m_cnt[w]++;
                if (m_cnt2[w] < 3) m_cnt2[w]++;
            end
            last_p   = t;
            pop_port = w;
        end
        e_busy = (t >= last_p) && (t <= last_p + G);
        t++;
    endtask

    task automatic check_all();
        logic [N-1:0][CB-1:0] ec;
        logic [N-1:0][1:0] ec2;
        for (int i = 0; i < N; i++) begin
            ec[i]  = CB'(m_cnt[i]);
            ec2[i] = 2'(m_cnt2[i]);
        end
        check("rx_data", 64'(rx_data), 64'(e_data));
        check("rx_data_flag", 64'(rx_data_flag), 64'(e_flag));
        check("uld", 64'(uld), 64'(e_uld));
        check("grant_port", 64'(grant_port), 64'(e_grant));
        check("arb_busy", 64'(arb_busy), 64'(e_busy));
        check("rx_count", 64'(ec), 64'(rx_count) ^ 64'(rx_count) ^ 64'(ec) ^ 64'(ec) ^ 64'(rx_count));
        check("rx_count_sat", 64'(rx_count_b), 64'(ec2));
    endtask

    task automatic drive_env();
        for (int i = 0; i < N; i++) begin
            rx_empty_uart[i] = (q[i].size() == 0);
            rx_data_uart[i]  = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (env_mode) begin
            if (pop_port >= 0) void'(q[pop_port].pop_front());
            drive_env();
        end
    endtask

    task automatic do_reset();
        reset_n_clk = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset_n_clk = 1'b1;
    endtask

    task automatic idle_gap();
        rx_empty_uart = '1;
        comms_busy    = 1'b0;
        repeat (G + 2) tick();
    endtask

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] empty;
        logic         busy;
        logic [N-1:0] exp_uld;
        logic [1:0]   exp_grant;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, prev;
        data_t d;
        tbl[0] = '{4'hF, 4'b1011, 1'b0, 4'b0100, 2'd2};
        tbl[1] = '{4'hF, 4'b0000, 1'b0, 4'b1000, 2'd3};
        tbl[2] = '{4'b1110, 4'b0000, 1'b0, 4'b0010, 2'd1};
        tbl[3] = '{4'hF, 4'b1100, 1'b0, 4'b0001, 2'd0};
        tbl[4] = '{4'b0111, 4'b0110, 1'b0, 4'b0001, 2'd0};
        tbl[5] = '{4'hF, 4'b1111, 1'b0, 4'b0000, 2'd0};
        tbl[6] = '{4'hF, 4'b0000, 1'b1, 4'b0000, 2'd0};
        tbl[7] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3};

        rx_data_uart  = '0;
        rx_empty_uart = '1;
        enable_posi   = '0;
        comms_busy    = 1'b0;
        clear_counts  = 1'b0;
        reset_n_clk   = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // vector table, pointer starts at 0
        for (int i = 0; i < N; i++) rx_data_uart[i] = 63'hA0 + 63'(i);
        rx_data_uart[2] = 63'h1234;
        foreach (tbl[v]) begin
            enable_posi   = tbl[v].en;
            rx_empty_uart = tbl[v].empty;
            comms_busy    = tbl[v].busy;
            tick();
            check($sformatf("tbl%0d_uld", v), 64'(uld), 64'(tbl[v].exp_uld));
            check($sformatf("tbl%0d_grant", v), 64'(grant_port),
                  64'(tbl[v].exp_grant));
            if (v == 0) begin
                check("tbl0_data", 64'(rx_data), 64'h1234);
                check("tbl0_count2", 64'(rx_count[2]), 64'd1);
            end
            idle_gap();
        end

        // all four requesting from reset: strict rotation, 4 apart
        do_reset();
        enable_posi   = '1;
        rx_empty_uart = '0;
        n = 0;
        prev = 0;
        for (int c = 0; c < 17; c++) begin
            tick();
            if (uld != '0) begin
                check("rr_order", 64'(grant_port), 64'(n % N));
                if (n > 0) check("rr_spacing", 64'(c - prev), 64'(G + 2));
                prev = c;
                n++;
                if (n == 4)
                    check("rr_counts", 64'(rx_count),
                          {16'd1, 16'd1, 16'd1, 16'd1});
            end
        end
        check("rr_grants", 64'(n), 64'd5);
        idle_gap();

        // comms_busy holds off port 1 for 10 cycles
        rx_empty_uart = 4'b1101;
        comms_busy    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("busy_no_uld", 64'({uld, rx_data_flag}), 64'd0);
        end
        comms_busy = 1'b0;
        tick();
        check("busy_release_uld", 64'(uld), 64'b0010);
        idle_gap();

        // port 3 requests but is disabled
        enable_posi   = 4'b0111;
        rx_empty_uart = 4'b0110;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("disabled_p3", 64'(uld[3]), 64'd0);
        end
        enable_posi = '1;
        idle_gap();

        // clear coincident with a grant wins
        rx_empty_uart = 4'b1101;
        clear_counts  = 1'b1;
        tick();
        clear_counts  = 1'b0;
        check("clear_wins_uld", 64'(uld), 64'b0010);
        check("clear_wins_cnt", 64'(rx_count[1]), 64'd0);
        idle_gap();

        // saturation on the 2-bit instance: five grants to port 1
        do_reset();
        rx_empty_uart = 4'b1101;
        repeat (20) tick();
        check("sat_main", 64'(rx_count[1]), 64'd5);
        check("sat_hold", 64'(rx_count_b[1]), 64'd3);
        idle_gap();

        // reset during FLAG, then re-arbitrate from port 0
        rx_empty_uart = 4'b1101;
        tick();
        check("pre_reset_uld", 64'(uld), 64'b0010);
        rx_empty_uart = 4'b0000;
        reset_n_clk = 1'b0;
        #1;
        check("async_reset", 64'({rx_data_flag, uld, grant_port, arb_busy}),
              64'd0);
        check("async_reset_data", 64'(rx_data), 64'd0);
        check("async_reset_cnt", 64'(rx_count), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n_clk = 1'b1;
        tick();
        check("post_reset_grant", 64'({uld, grant_port}), {58'd0, 4'b0001, 2'd0});
        idle_gap();

        // random traffic with a UART queue model
        do_reset();
        env_mode = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        drive_env();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) begin
                    d = {$urandom, $urandom};
                    q[i].push_back(d);
                end
            drive_env();
            for (int i = 0; i < N; i++)
                enable_posi[i] = ($urandom_range(9) != 0);
            comms_busy   = ($urandom_range(4) == 0);
            clear_counts = ($urandom_range(63) == 0);
            tick();
        end
        clear_counts = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
